// File: rtl/seq_checker_pkg.sv
// Shared types and widths for the counter-stream sequence checker.
package seq_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int ERR_CNT_W = 8;
    localparam int OK_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear, async active-low reset.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_checker.sv
// Locks onto an incrementing counter stream and counts sequence/flag errors.
// Define SEQ_CHECKER_STATS_EN to build the matched-sample counter behind ok_cnt.
module seq_checker
    import seq_checker_pkg::*;
#(
    parameter int PORT_ID    = 0,
    parameter int IN_WIDTH   = 4,
    parameter int LOCK_COUNT = 2,
    parameter int LOSS_COUNT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in0,
    input  logic [IN_WIDTH-1:0]  in,
    input  logic                 clr,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 res,
    output logic [OK_CNT_W-1:0]  ok_cnt,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] SYNC   = ST_SYNC;
    localparam logic [1:0] LOCKED = ST_LOCKED;

    localparam int SYNC_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = (LOSS_COUNT < 2) ? 1 : $clog2(LOSS_COUNT + 1);
    localparam logic [SYNC_W-1:0] LOCK_TGT = SYNC_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0] LOSS_TGT = MISS_W'(LOSS_COUNT);

    logic [1:0]          state;
    logic [IN_WIDTH-1:0] exp_val;
    logic [IN_WIDTH-1:0] prev;
    logic [SYNC_W-1:0]   sync_cnt;
    logic [MISS_W-1:0]   miss_cnt;
    logic [SYNC_W-1:0]   sync_nxt;
    logic [MISS_W-1:0]   miss_nxt;
    logic                in_match;
    logic                sample_bad;
    logic                err_inc;

    // Handshake: in_valid qualifies in/in0 for one cycle; there is no ready,
    // every valid sample is consumed on that edge unless clr is also high.
    assign in_match   = (in == exp_val);
    assign sample_bad = !in_match || (in0 != (|prev));
    assign sync_nxt   = sync_cnt + 1'b1;
    assign miss_nxt   = miss_cnt + 1'b1;
    assign err_inc    = in_valid && !clr && (state == LOCKED) && sample_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            exp_val  <= '0;
            prev     <= '0;
            sync_cnt <= '0;
            miss_cnt <= '0;
            err      <= 1'b0;
        end else if (clr) begin
            state    <= IDLE;
            sync_cnt <= '0;
            miss_cnt <= '0;
            err      <= 1'b0;
        end else if (in_valid) begin
            // Always follow the received value so a single slip costs one error.
            exp_val <= in + 1'b1;
            prev    <= in;
            case (state)
                IDLE: begin
                    sync_cnt <= SYNC_W'(1);
                    state    <= SYNC;
                end
                SYNC: begin
                    if (in_match) begin
                        sync_cnt <= sync_nxt;
                        miss_cnt <= '0;
                        if (sync_nxt == LOCK_TGT) begin
                            state <= LOCKED;
                        end
                    end else begin
                        sync_cnt <= SYNC_W'(1);
                    end
                end
                LOCKED: begin
                    if (sample_bad) begin
                        err <= 1'b1;
                        if (miss_nxt == LOSS_TGT) begin
                            state    <= SYNC;
                            sync_cnt <= SYNC_W'(1);
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_nxt;
                        end
                    end else begin
                        miss_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.WIDTH(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .clr   (clr),
        .count (err_cnt)
    );

`ifdef SEQ_CHECKER_STATS_EN
    logic ok_inc;
    assign ok_inc = in_valid && !clr && (state == LOCKED) && !sample_bad;

    sat_counter #(.WIDTH(OK_CNT_W)) u_ok_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ok_inc),
        .clr   (clr),
        .count (ok_cnt)
    );
`else
    assign ok_cnt = '0;
`endif

    assign locked    = (state == LOCKED);
    assign res       = locked && !err;
    assign state_dbg = state;

endmodule
